led_req_arbiter: RTL and testbench

- Shares the 4-LED bank between N_REQ requesters, e.g. alarm, link status and heartbeat.
- Each requester raises a request and selects a display mode.
- The block grants one requester at a time and generates its LED pattern from an internal tick.
- A minimum display time stops the LEDs flickering. Sits between status sources and the board LED pins.

---
 rtl/led_pkg.sv | 27 ++
 rtl/led_pattern_gen.sv | 35 +++
 rtl/led_req_arbiter.sv | 149 ++++++++++++++
 tb/tb_led_req_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the LED request arbiter: display modes, FSM states
// and the per-mode start pattern.
package led_pkg;

  localparam int LED_W = 4;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_SOLID = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_CHASE = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  function automatic logic [LED_W-1:0] start_pattern(mode_e m);
    case (m)
      MODE_SOLID, MODE_BLINK: return 4'b1111;
      MODE_CHASE:             return 4'b0001;
      default:                return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_gen.sv
// LED pattern register: loads the mode's start value on start and advances
// BLINK/CHASE on each tick. start overrides a coincident tick.
module led_pattern_gen
  import led_pkg::*;
(
  input  logic             sys_clk,
  input  logic             rst_n,
  input  mode_e            mode,
  input  logic             start,
  input  logic             tick,
  output logic [LED_W-1:0] led
);

  mode_e            mode_q;
  logic [LED_W-1:0] pat_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
      pat_q  <= '0;
    end else if (start) begin
      mode_q <= mode;
      pat_q  <= start_pattern(mode);
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: pat_q <= ~pat_q;
        MODE_CHASE: pat_q <= {pat_q[LED_W-2:0], pat_q[LED_W-1]};
        default:    pat_q <= pat_q;
      endcase
    end
  end

  assign led = pat_q;

endmodule

// File: rtl/led_req_arbiter.sv
// Shares the LED bank between N_REQ requesters with a minimum display time.
// Fixed priority by default; define LED_ROUND_ROBIN_EN for round-robin time-slicing.
//
// state | meaning
// IDLE  | no grant, LEDs off
// SHOW  | one requester granted, its pattern on the LEDs
module led_req_arbiter
  import led_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TICK_CYCLES = 10_000_000,
  parameter int MIN_TICKS   = 5
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] mode,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic [LED_W-1:0]   led
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int HW = (MIN_TICKS > 0) ? $clog2(MIN_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MIN_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = (MIN_TICKS > 0) ? HW'(MIN_TICKS - 1) : '0;

  state_e           state_q, state_d;
  logic [IW-1:0]    cur_q, cur_d;
  logic [IW-1:0]    winner;
  logic [N_REQ-1:0] cur_mask;
  logic [TW-1:0]    tick_cnt;
  logic [HW-1:0]    hold_cnt;
  logic             tick, min_met, hold_done, start;
  logic [LED_W-1:0] pat;

  assign cur_mask = N_REQ'(1) << cur_q;
  assign tick     = (state_q == SHOW) && (tick_cnt == TICK_LAST);
  assign min_met  = (hold_cnt == HOLD_MAX);
  // The final tick counts as met on its own edge, so a grant lasts exactly
  // MIN_TICKS*TICK_CYCLES cycles and a switch always lands on a tick.
  assign hold_done = min_met || (tick && (hold_cnt == HOLD_LAST));

`ifdef LED_ROUND_ROBIN_EN
  logic [IW-1:0] last_grant;

  // Search ascends from last_grant+1 with wrap; the nearest hit wins.
  always_comb begin
    int idx;
    winner = '0;
    idx    = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (req[IW'(idx)]) winner = IW'(idx);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)     last_grant <= IW'(N_REQ - 1);
    else if (start) last_grant <= cur_d;
  end
`else
  always_comb begin
    winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[IW'(i)]) winner = IW'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SHOW;
          cur_d   = winner;
          start   = 1'b1;
        end
      end
      SHOW: begin
        if (hold_done) begin
`ifdef LED_ROUND_ROBIN_EN
          if ((req & ~cur_mask) != '0) begin
            cur_d = winner;
            start = 1'b1;
          end else if (!req[cur_q]) begin
            state_d = IDLE;
          end
`else
          if (!req[cur_q]) begin
            if (|req) begin
              cur_d = winner;
              start = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else if (winner > cur_q) begin
            cur_d = winner;
            start = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      hold_cnt <= '0;
    end else if (start || (state_d != SHOW)) begin
      tick_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick && !min_met) hold_cnt <= hold_cnt + 1'b1;
    end
  end

  led_pattern_gen u_pattern (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .mode    (mode_e'(mode[{cur_d, 1'b0} +: 2])),
    .start   (start),
    .tick    (tick),
    .led     (pat)
  );

  assign busy  = (state_q == SHOW);
  assign grant = busy ? cur_mask : '0;
  assign led   = busy ? pat : '0;

endmodule

// File: tb/tb_led_req_arbiter.sv
// Self-checking bench for led_req_arbiter: directed steps plus random requests
// compared each cycle against a grant-age based reference model.
module tb_led_req_arbiter;

  localparam int N   = 4;
  localparam int TC  = 4;
  localparam int MT  = 2;
  localparam int HOLD_CYCLES = MT * TC;

  logic         sys_clk = 1'b0;
  logic         rst_n   = 1'b0;
  logic [N-1:0] req     = '0;
  logic [2*N-1:0] mode  = '0;
  logic [N-1:0] grant;
  logic         busy;
  logic [3:0]   led;

  int passes = 0;
  int total  = 0;

  // model state: who holds the grant, how many cycles it has been shown
  int         m_busy = 0;
  int         m_cur  = 0;
  int         m_age  = 0;
  int         m_last = N - 1;
  logic [1:0] m_mode = 2'b00;

  led_req_arbiter #(.N_REQ(N), .TICK_CYCLES(TC), .MIN_TICKS(MT)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .req     (req),
    .mode    (mode),
    .grant   (grant),
    .busy    (busy),
    .led     (led)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int pick(input logic [N-1:0] r, input int last);
    int w;
    w = -1;
`ifdef LED_ROUND_ROBIN_EN
    for (int k = N; k >= 1; k--) if (r[(last + k) % N]) w = (last + k) % N;
`else
    for (int i = 0; i < N; i++) if (r[i]) w = i;
    if (last < 0) w = -2;
`endif
    return w;
  endfunction

  function automatic logic [3:0] exp_led();
    int t;
    if (m_busy == 0) return 4'b0000;
    t = m_age / TC;
    case (m_mode)
      2'b01:   return 4'b1111;
      2'b10:   return (t % 2 == 0) ? 4'b1111 : 4'b0000;
      2'b11:   return 4'b0001 << (t % 4);
      default: return 4'b0000;
    endcase
  endfunction

  task automatic new_grant(input int i);
    logic [2*N-1:0] mv;
    mv     = mode >> (2 * i);
    m_busy = 1;
    m_cur  = i;
    m_age  = 0;
    m_last = i;
    m_mode = mv[1:0];
  endtask

  task automatic model_edge();
    logic [N-1:0] others;
    int held;
    if (m_busy == 0) begin
      if (req != '0) new_grant(pick(req, m_last));
    end else begin
      held   = (m_age + 1 >= HOLD_CYCLES) ? 1 : 0;
      m_age  = m_age + 1;
      others = req & ~(N'(1) << m_cur);
      if (held != 0) begin
`ifdef LED_ROUND_ROBIN_EN
        if (others != '0)     new_grant(pick(req, m_last));
        else if (!req[m_cur]) m_busy = 0;
`else
        if (!req[m_cur]) begin
          if (others != '0) new_grant(pick(req, m_last));
          else              m_busy = 0;
        end else if (pick(req, m_last) > m_cur) begin
          new_grant(pick(req, m_last));
        end
`endif
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = (m_busy != 0) ? (N'(1) << m_cur) : '0;
    check({tag, "_grant"}, 8'(grant), 8'(eg));
    check({tag, "_busy"},  8'(busy),  8'(m_busy != 0));
    check({tag, "_led"},   8'(led),   8'(exp_led()));
  endtask

  task automatic step(input string tag);
    @(posedge sys_clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    #12;
    check("reset_grant", 8'(grant), 8'h00);
    check("reset_busy",  8'(busy),  8'h00);
    check("reset_led",   8'(led),   8'h00);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // CHASE on requester 0
    req  = 4'b0001;
    mode = 8'b0000_0011;
    step("chase_grant");
    check("chase_start", 8'(led), 8'h01);
    steps(4, "chase");
    check("chase_t1", 8'(led), 8'h02);
    steps(4, "chase");
    check("chase_t2", 8'(led), 8'h04);
    steps(4, "chase");
    check("chase_t3", 8'(led), 8'h08);
    steps(4, "chase");
    check("chase_wrap", 8'(led), 8'h01);
    req = 4'b0000;
    step("chase_release");
    check("chase_idle", 8'(busy), 8'h00);

    // higher request arrives during min hold
    req  = 4'b0001;
    mode = 8'b0100_0001;
    step("hold_grant");
    steps(4, "hold");
    req = 4'b1001;
    steps(3, "hold");
    check("hold_keep", 8'(grant), 8'h01);
    step("preempt");
    check("preempt_grant", 8'(grant), 8'h08);
    check("preempt_led",   8'(led),   8'h0f);

    // simultaneous requests from idle
    req = 4'b0000;
    steps(9, "drain");
    req = 4'b1001;
    step("simul");
    check("simul_grant", 8'(grant), 8'h08);
    steps(4, "simul");
    req = 4'b0001;
    steps(3, "simul");
    check("simul_hold", 8'(grant), 8'h08);
    step("simul_switch");
    check("simul_next", 8'(grant), 8'h01);

    // early drop still gets the full display time
    req = 4'b0000;
    steps(9, "drain");
    req  = 4'b0001;
    mode = 8'b0000_0010;
    step("blink_grant");
    req = 4'b0000;
    steps(7, "blink_drop");
    check("blink_still", 8'(busy), 8'h01);
    step("blink_end");
    check("blink_idle", 8'(grant), 8'h00);

    // asynchronous reset mid-BLINK
    req  = 4'b0100;
    mode = 8'b0010_0000;
    steps(6, "rst_pre");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_grant", 8'(grant), 8'h00);
    check("rst_busy",  8'(busy),  8'h00);
    check("rst_led",   8'(led),   8'h00);
    m_busy = 0;
    m_last = N - 1;
    @(negedge sys_clk);
    rst_n = 1'b1;
    step("rst_regrant");
    check("rst_regrant_led", 8'(led), 8'h0f);

    // random traffic against the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) mode = 8'($urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
